// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract sequencer around one 4-bit adder.
// Optional signed-overflow output ovf when NSA_OVERFLOW_FLAG_EN is defined.

module adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  // Ripple the carry bit by bit through the nibble
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NSA_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic                 accept;
  logic                 last;
  logic [NIB-1:0][3:0]  a_reg;
  logic [NIB-1:0][3:0]  b_reg;
  logic [NIB-1:0][3:0]  sum_r;
  logic                 carry;
  logic [IW-1:0]        idx;
  logic                 cout_r;
  logic [3:0]           add_a;
  logic [3:0]           add_b;
  logic [3:0]           add_s;
  logic                 add_co;

  assign add_a = a_reg[idx];
  assign add_b = b_reg[idx];
  assign last  = (idx == IW'(NIB - 1));

  adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .s    (add_s),
    .cout (add_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state, handshake outputs and start acceptance
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        accept   = start;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, per-nibble accumulate and final carry capture
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= sub ? ~b : b;
      carry <= sub;
      idx   <= '0;
    end else if (busy) begin
      sum_r[idx] <= add_s;
      carry      <= add_co;
      if (last) cout_r <= add_co;
      else      idx    <= idx + 1'b1;
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

`ifdef NSA_OVERFLOW_FLAG_EN
  logic ovf_r;
  logic msb_cin;

  assign msb_cin = add_a[3] ^ add_b[3] ^ add_s[3];

  // Signed overflow: carry into MSB differs from carry out of MSB
  always_ff @(posedge clk) begin
    if (reset)             ovf_r <= 1'b0;
    else if (busy && last) ovf_r <= msb_cin ^ add_co;
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed table, corner sequences
// and random operations checked against an arithmetic model.

module tb_nibble_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NSA_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef NSA_OVERFLOW_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         b2b;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic s, output logic [W-1:0] r,
                                output logic c, output logic o);
    int ux, uy, sx, sy, st, ut;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      ut = ux - uy;
      c  = (ux >= uy);
      st = sx - sy;
    end else begin
      ut = ux + uy;
      c  = (ut >= 65536);
      st = sx + sy;
    end
    r = ut[W-1:0];
    o = (st > 32767) || (st < -32768);
  endfunction

  // Called at a negedge: start is seen by the next posedge
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s);
    start = 1'b1;
    a     = x;
    b     = y;
    sub   = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int nbusy);
    lat   = lat0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_result(input string tag, input logic [W-1:0] es,
                            input logic ec, input logic eo);
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef NSA_OVERFLOW_FLAG_EN
    chk({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x in model");
`endif
  endtask

  initial begin
    int lat, nb, nd;
    logic [W-1:0] ra, rb, rs, held;
    logic rsub, rc, ro;

    tv[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    tv[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    tv[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tv[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk_result("rst", 16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("idle busy", 32'(busy), 0);
    chk("idle done", 32'(done), 0);

    // Directed table; b2b entries start in the previous DONE cycle
    for (int i = 0; i < 6; i++) begin
      issue(tv[i].a, tv[i].b, tv[i].sub);
      wait_done(1, lat, nb);
      chk($sformatf("v%0d latency", i), 32'(lat), NIB + 1);
      chk($sformatf("v%0d busy cycles", i), 32'(nb), NIB);
      chk($sformatf("v%0d busy@done", i), 32'(busy), 0);
      chk_result($sformatf("v%0d", i), tv[i].es, tv[i].ec, tv[i].eo);
      if (i == 5 || !tv[i + 1].b2b) begin
        held = sum;
        @(negedge clk);
        chk($sformatf("v%0d done pulse", i), 32'(done), 0);
        chk($sformatf("v%0d hold", i), 32'(sum), 32'(tv[i].es));
        @(negedge clk);
      end
    end

    // Start during RUN is ignored
    model(16'h0102, 16'h0304, 1'b0, rs, rc, ro);
    issue(16'h0102, 16'h0304, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    sub   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat, nb);
    chk("ign latency", 32'(lat), NIB + 1);
    chk_result("ign", rs, rc, ro);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ign extra done", 32'(nd), 0);
    chk("ign hold", 32'(sum), 32'(rs));

    // Reset in the 3rd RUN cycle discards the operation
    issue(16'h4444, 16'h1111, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst done", 32'(done), 0);
    chk_result("mid rst", 16'h0000, 1'b0, 1'b0);
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("mid rst quiet", 32'(nd), 0);
    issue(16'h4444, 16'h1111, 1'b1);
    wait_done(1, lat, nb);
    chk("post rst latency", 32'(lat), NIB + 1);
    chk_result("post rst", 16'h3333, 1'b1, 1'b0);
    @(negedge clk);

    // Random operations; operands scrambled after acceptance
    for (int k = 0; k < 40; k++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rsub = 1'($urandom);
      if (k % 8 == 0) rb = ra;
      model(ra, rb, rsub, rs, rc, ro);
      issue(ra, rb, rsub);
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      wait_done(1, lat, nb);
      chk($sformatf("rnd%0d latency", k), 32'(lat), NIB + 1);
      chk_result($sformatf("rnd%0d", k), rs, rc, ro);
      if ($urandom_range(1, 0) == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
